// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage downstream of the program counter.
//
// Takes the PC's 12-bit address and fetch/execute phase and reads the
// addressed byte from program memory over a req/valid handshake. The byte is
// latched as a 4-bit opcode and a 4-bit operand. While memory has not
// answered, the PC is stalled so the fetch phase lasts through the memory
// latency. A timeout counter abandons a fetch to a dead memory, loads
// NOP_BYTE and raises a sticky error flag.
//
// Ports:
//   clk        in   system clock, rising edge
//   Rst        in   asynchronous active-high reset
//   addr       in   [11:0] current program address from the PC
//   phase      in   PC phase, 0 = fetch, 1 = execute
//   stall      out  combinational hold request to the PC
//   mem_req    out  registered memory request
//   mem_addr   out  [11:0] registered request address
//   mem_rdata  in   [7:0] memory read data
//   mem_valid  in   memory response strobe
//   instr      out  [3:0] opcode of the last completed fetch
//   oprnd      out  [3:0] operand of the last completed fetch
//   ir_valid   out  instruction register holds a completed fetch
//   fetch_err  out  sticky timeout flag, cleared only by Rst
module fetch_unit #(
    parameter int       TIMEOUT  = 15,
    parameter bit [7:0] NOP_BYTE = 8'h00
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic [11:0] addr,
    input  logic        phase,
    output logic        stall,
    output logic        mem_req,
    output logic [11:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_valid,
    output logic [3:0]  instr,
    output logic [3:0]  oprnd,
    output logic        ir_valid,
    output logic        fetch_err
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EXEC = 2'd2
    } state_t;

    state_t      state_q,     state_d;
    logic [7:0]  cnt_q,       cnt_d;
    logic        mem_req_q,   mem_req_d;
    logic [11:0] mem_addr_q,  mem_addr_d;
    logic [7:0]  ir_q,        ir_d;
    logic        ir_valid_q,  ir_valid_d;
    logic        fetch_err_q, fetch_err_d;

    logic        timed_out;

    assign timed_out = (cnt_q == TIMEOUT_C);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        ir_d        = ir_q;
        ir_valid_d  = ir_valid_q;
        fetch_err_d = fetch_err_q;
        stall       = 1'b0;

        case (state_q)
            // IDLE and EXEC behave identically once the PC is back in the
            // fetch phase: hold the PC and launch the next request.
            ST_IDLE, ST_EXEC: begin
                if (!phase) begin
                    stall      = 1'b1;
                    mem_req_d  = 1'b1;
                    mem_addr_d = addr;
                    ir_valid_d = 1'b0;
                    cnt_d      = 8'd0;
                    state_d    = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // Data takes priority over a coincident timeout.
                stall = !mem_valid && !timed_out;
                if (mem_valid) begin
                    ir_d       = mem_rdata;
                    ir_valid_d = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = ST_EXEC;
                end else if (timed_out) begin
                    ir_d        = NOP_BYTE;
                    ir_valid_d  = 1'b1;
                    fetch_err_d = 1'b1;
                    mem_req_d   = 1'b0;
                    state_d     = ST_EXEC;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= 12'd0;
            ir_q        <= 8'd0;
            ir_valid_q  <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign instr     = ir_q[7:4];
    assign oprnd     = ir_q[3:0];
    assign ir_valid  = ir_valid_q;
    assign fetch_err = fetch_err_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly downstream of the program counter. It consumes the PC's 12-bit `addr` and `phase` outputs and fetches the addressed byte from program memory over a req/valid handshake. It latches the byte into the instruction register as a 4-bit opcode and a 4-bit operand for the execute logic. While memory has not answered, it stalls the PC so the fetch phase stretches to cover any memory latency; a timeout guards against a dead memory.

## Interface
- `TIMEOUT`, default 15: maximum WAIT cycles before a fetch is abandoned (1..255).
- `NOP_BYTE`, default 8'h00: byte loaded into the instruction register on a timed-out fetch.

Ports:
- `clk`  in  1  single system clock; everything is rising-edge.
- `Rst`  in  1  reset; asynchronous, active-high.
- `addr`  in  12  current program address from the PC.
- `phase`  in  1  PC phase; 0 = fetch, 1 = execute.
- `stall`  out  1  combinational; when high, the PC must hold both `addr` and `phase`.
- `mem_req`  out  1  registered memory request.
- `mem_addr`  out  12  registered address, valid while `mem_req`=1.
- `mem_rdata`  in  8  memory read data, sampled only when `mem_valid`=1 in WAIT.
- `mem_valid`  in  1  memory response strobe.
- `instr`  out  4  opcode, equal to `mem_rdata[7:4]` of the last completed fetch.
- `oprnd`  out  4  operand, equal to `mem_rdata[3:0]` of the last completed fetch.
- `ir_valid`  out  1  `instr`/`oprnd` hold a completed fetch for the current execute phase.
- `fetch_err`  out  1  sticky flag: some fetch timed out; cleared only by `Rst`.

## Operation
- The block has three states: IDLE, WAIT and EXEC. Reset enters IDLE.
- Reset values:
  - `mem_req`=0, `mem_addr`=0.
  - `instr`=0, `oprnd`=0.
  - `ir_valid`=0, `fetch_err`=0.
  - Timeout counter = 0.
- IDLE:
  - If `phase`=0, `stall`=1. On the next edge: `mem_req`←1, `mem_addr`←`addr`, `ir_valid`←0, counter←0, go to WAIT.
  - If `phase`=1, stay in IDLE with `stall`=0.
- WAIT:
  - `mem_req` and `mem_addr` are held stable.
  - `stall` = !`mem_valid` && (counter != `TIMEOUT`).
  - If `mem_valid`=1: on the edge, `{instr,oprnd}`←`mem_rdata`, `ir_valid`←1, `mem_req`←0, go to EXEC.
  - Else if counter = `TIMEOUT`: on the edge, `{instr,oprnd}`←`NOP_BYTE`, `ir_valid`←1, `fetch_err`←1, `mem_req`←0, go to EXEC.
  - Otherwise the counter increments by 1; its width is 8 bits and it never wraps, because it stops at `TIMEOUT`.
- EXEC:
  - `stall`=0, and `instr`/`oprnd`/`ir_valid` are held.
  - When `phase`=0 is seen again, behave exactly as IDLE with `phase`=0: `stall`=1 and issue the next request on the following edge.
- `mem_valid` is ignored outside WAIT; a stray strobe changes nothing.
- `mem_valid` and timeout in the same cycle: the data wins, and `fetch_err` is not set.
- A PC load (jump) occurs only in the execute phase, so no flush is needed. The next fetch uses whatever `addr` holds when `phase` returns to 0.
- `Rst` asserted mid-WAIT:
  - `mem_req` drops immediately (asynchronously), without waiting for a clock edge.
  - State returns to IDLE, and a late `mem_valid` after reset is ignored.

## Timing
- The minimum fetch phase is 2 cycles, using memory that answers with `mem_valid` one cycle after `mem_req` rises:
  - Cycle N: IDLE with `phase`=0; `stall`=1.
  - Cycle N+1: WAIT with `mem_valid`=1; `stall`=0.
  - Edge ending N+1: the PC toggles to `phase`=1 and `ir_valid`=1.
- For a memory latency of L cycles (`mem_valid` high in the L-th WAIT cycle), the fetch phase is L+1 cycles.
- A timed-out fetch lasts `TIMEOUT`+2 cycles:
  - 1 IDLE cycle.
  - `TIMEOUT`+1 WAIT cycles, which let the counter run 0..`TIMEOUT`.
- `stall` is combinational from state, counter and `mem_valid`, so the PC must sample it at the same edge. There is no combinational path from `mem_rdata`.
- `instr`/`oprnd` are stable from the capture edge until the next capture, always at least the whole execute phase.

## Test plan
- Reset:
  - Stimulus: `Rst`=1 at t=4 for 6 time units, with `phase`=0.
  - Required: all outputs at their reset values, and `mem_req` low during reset.
  - After release: `stall`=1 in the first IDLE cycle and a request issued on the next edge.
- 1-cycle memory:
  - Stimulus: `addr`=12'h359, memory returns 8'hA7 one cycle after `mem_req`.
  - Required: `mem_addr`=12'h359, `stall` high for exactly 1 cycle, then `instr`=4'hA, `oprnd`=4'h7, `ir_valid`=1 at the edge where the PC enters phase 1.
- 4-cycle latency:
  - Stimulus: `addr`=12'h004, `mem_valid` in the 4th WAIT cycle with 8'h3C.
  - Required: `stall` high for 4 cycles, `mem_addr` stable throughout, then `instr`=4'h3, `oprnd`=4'hC.
- Timeout:
  - Stimulus: `TIMEOUT`=3, `mem_valid` never asserted.
  - Required: after 4 WAIT cycles `{instr,oprnd}`=8'h00, `fetch_err`=1; it stays 1 through later good fetches until `Rst`.
- Simultaneous data and timeout:
  - Stimulus: `TIMEOUT`=3, `mem_valid` with 8'h5E in the 4th WAIT cycle (counter=3).
  - Required: `{instr,oprnd}`=8'h5E, `fetch_err`=0.
- Stray strobe and mid-WAIT reset:
  - Stimulus: `mem_valid` pulses with 8'hFF during EXEC.
  - Required: no change to `instr`/`oprnd`.
  - Stimulus: `Rst` pulses during WAIT.
  - Required: `mem_req` falls immediately, and a `mem_valid` pulse one cycle later is ignored.
